// File: rtl/instr_encoder_if.sv
// Symbolic-instruction handshake bundle between boot/test loader and encoder.
// Master drives fields and valid; slave returns ready.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [3:0]  in_rd;
    logic [3:0]  in_rs;
    logic [3:0]  in_rt;
    logic [15:0] in_imm;

    modport master (
        output in_valid, in_op, in_rd, in_rs, in_rt, in_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs, in_rt, in_imm,
        output in_ready
    );
endinterface

// File: rtl/instr_encoder.sv
// Purpose: range-check and pack symbolic instructions into 16-bit words, write them to imem; LI expands to LLB+LHB.
// Latency: accept at edge N -> imem write at N+1 (LHB half of LI at N+2).
// Backpressure: in_ready low in EXP2, HALTED, when full, or while base_load is asserted.
module instr_encoder #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] BASE_RST = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    instr_encoder_if.slave    in_bus,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [15:0]       im_wdata,
    output logic              done,
    output logic [1:0]        err
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_EXP2   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_BADOP = 2'b10;
    localparam logic [1:0] ERR_OVFL  = 2'b11;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic              full_q;
    logic [1:0]        err_q;
    logic [15:0]       lhb_q;

    logic signed [15:0] imm_s;
    logic               accept;
    logic               op_legal;
    logic               is_li;
    logic               is_hlt;
    logic               range_ok;
    logic [15:0]        enc_word;
    logic [15:0]        llb_word;
    logic [15:0]        lhb_word;

    logic               wr_en;
    logic [15:0]        wr_data;
    logic               err_set;
    logic [1:0]         err_code;
    logic               lhb_load;

    function automatic logic in_rng(input logic signed [15:0] v,
                                    input logic signed [15:0] lo,
                                    input logic signed [15:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    assign imm_s           = signed'(in_bus.in_imm);
    assign in_bus.in_ready = (state_q == ST_RUN) && !full_q && !base_load;
    assign accept          = in_bus.in_valid && in_bus.in_ready;
    assign done            = (state_q == ST_HALTED);
    assign err             = err_q;

    assign is_li    = (in_bus.in_op == 5'h10);
    assign is_hlt   = (in_bus.in_op == 5'h0F);
    assign op_legal = !in_bus.in_op[4] || is_li;
    assign llb_word = {4'hB, in_bus.in_rd, in_bus.in_imm[7:0]};
    assign lhb_word = {4'hA, in_bus.in_rd, in_bus.in_imm[15:8]};

    // Field packing and immediate range check for real ISA opcodes.
    always_comb begin
        enc_word = 16'h0000;
        range_ok = 1'b1;
        case (in_bus.in_op[3:0])
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin
                enc_word = {in_bus.in_op[3:0], in_bus.in_rd, in_bus.in_rs, in_bus.in_rt};
            end
            4'h5, 4'h6, 4'h7: begin
                enc_word = {in_bus.in_op[3:0], in_bus.in_rd, in_bus.in_rs, in_bus.in_imm[3:0]};
                range_ok = in_rng(imm_s, 16'sd0, 16'sd15);
            end
            4'h8: begin
                enc_word = {in_bus.in_op[3:0], in_bus.in_rd, in_bus.in_rs, in_bus.in_imm[3:0]};
                range_ok = in_rng(imm_s, -16'sd8, 16'sd7);
            end
            4'h9: begin
                enc_word = {in_bus.in_op[3:0], in_bus.in_rt, in_bus.in_rs, in_bus.in_imm[3:0]};
                range_ok = in_rng(imm_s, -16'sd8, 16'sd7);
            end
            4'hA, 4'hB: begin
                enc_word = {in_bus.in_op[3:0], in_bus.in_rd, in_bus.in_imm[7:0]};
                range_ok = in_rng(imm_s, -16'sd128, 16'sd255);
            end
            4'hC: begin
                enc_word = {in_bus.in_op[3:0], in_bus.in_rd[2:0], in_bus.in_imm[8:0]};
                range_ok = in_rng(imm_s, -16'sd256, 16'sd255);
            end
            4'hD: begin
                enc_word = {in_bus.in_op[3:0], in_bus.in_imm[11:0]};
                range_ok = in_rng(imm_s, -16'sd2048, 16'sd2047);
            end
            4'hE: begin
                enc_word = {in_bus.in_op[3:0], 4'h0, in_bus.in_rs, 4'h0};
            end
            default: begin
                enc_word = 16'hF000;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        wr_en    = 1'b0;
        wr_data  = enc_word;
        err_set  = 1'b0;
        err_code = 2'b00;
        lhb_load = 1'b0;
        if (base_load) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (accept) begin
                        if (!op_legal) begin
                            err_set  = 1'b1;
                            err_code = ERR_BADOP;
                        end else if (is_li) begin
                            // LI needs two slots; with only the last one free, refuse and stop.
                            if (ptr_q == PTR_MAX) begin
                                err_set  = 1'b1;
                                err_code = ERR_OVFL;
                                state_d  = ST_HALTED;
                            end else begin
                                wr_en    = 1'b1;
                                wr_data  = llb_word;
                                lhb_load = 1'b1;
                                state_d  = ST_EXP2;
                            end
                        end else if (!range_ok) begin
                            err_set  = 1'b1;
                            err_code = ERR_RANGE;
                        end else begin
                            wr_en = 1'b1;
                            if (is_hlt) begin
                                state_d = ST_HALTED;
                            end
                        end
                    end
                end
                ST_EXP2: begin
                    wr_en   = 1'b1;
                    wr_data = lhb_q;
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_HALTED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            ptr_q    <= BASE_RST;
            full_q   <= 1'b0;
            err_q    <= 2'b00;
            lhb_q    <= 16'h0000;
            im_we    <= 1'b0;
            im_addr  <= BASE_RST;
            im_wdata <= 16'h0000;
        end else begin
            state_q <= state_d;
            im_we   <= wr_en;
            if (base_load) begin
                ptr_q  <= base_addr;
                full_q <= 1'b0;
                err_q  <= 2'b00;
            end else begin
                if (wr_en) begin
                    im_addr  <= ptr_q;
                    im_wdata <= wr_data;
                    ptr_q    <= ptr_q + 1'b1;
                    if (ptr_q == PTR_MAX) begin
                        full_q <= 1'b1;
                    end
                end
                if (err_set && (err_q == 2'b00)) begin
                    err_q <= err_code;
                end
            end
            if (lhb_load) begin
                lhb_q <= lhb_word;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: expected writes queued at issue, a negedge monitor pops and compares.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        base_load = 1'b0;
    logic [7:0]  base_addr = 8'h00;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [15:0] im_wdata;
    logic        done;
    logic [1:0]  err;

    instr_encoder_if bus ();

    instr_encoder #(.ADDR_W(8), .BASE_RST(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .base_load (base_load),
        .base_addr (base_addr),
        .in_bus    (bus.slave),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [23:0] sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: every imem write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && im_we) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: addr %h data %h, required no write", im_addr, im_wdata);
            end else begin
                logic [23:0] e;
                e = sb.pop_front();
                chk("imem_write", 32'({im_addr, im_wdata}), 32'(e));
            end
        end
    end

    task automatic expect_wr(input logic [7:0] a, input logic [15:0] d);
        sb.push_back({a, d});
    endtask

    task automatic send(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs,
                        input logic [3:0] rt, input logic [15:0] imm);
        bit got;
        got = 1'b0;
        bus.in_op    = op;
        bus.in_rd    = rd;
        bus.in_rs    = rs;
        bus.in_rt    = rt;
        bus.in_imm   = imm;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bus.in_ready) got = 1'b1;
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready %b, required 1", bus.in_ready);
        end else begin
            @(posedge clk);
        end
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic do_base(input logic [7:0] a);
        base_addr = a;
        base_load = 1'b1;
        @(negedge clk);
        chk("ready_during_base_load", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1 base_load = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_op    = 5'h00;
        bus.in_rd    = 4'h0;
        bus.in_rs    = 4'h0;
        bus.in_rt    = 4'h0;
        bus.in_imm   = 16'h0000;

        #12;
        chk("rst_im_we",    32'(im_we),    32'd0);
        chk("rst_im_addr",  32'(im_addr),  32'h00);
        chk("rst_im_wdata", 32'(im_wdata), 32'h0000);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_err",      32'(err),      32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // ADD
        expect_wr(8'h00, 16'h0345);
        send(5'h00, 4'd3, 4'd4, 4'd5, 16'h0000);
        idle(2);
        chk("add_drained", 32'(sb.size()), 32'd0);

        // LW ok, SW out of range
        do_base(8'h00);
        expect_wr(8'h00, 16'h827F);
        send(5'h08, 4'd2, 4'd7, 4'd0, 16'hFFFF);
        send(5'h09, 4'd0, 4'd7, 4'd2, 16'd8);
        idle(2);
        chk("sw_range_err", 32'(err), 32'd1);
        expect_wr(8'h01, 16'h0111);
        send(5'h00, 4'd1, 4'd1, 4'd1, 16'h0000);
        idle(2);
        chk("lw_sw_drained", 32'(sb.size()), 32'd0);

        // LI expansion
        do_base(8'h00);
        chk("err_cleared", 32'(err), 32'd0);
        expect_wr(8'h00, 16'hB6EF);
        expect_wr(8'h01, 16'hA6BE);
        send(5'h10, 4'd6, 4'd0, 4'd0, 16'hBEEF);
        chk("li_exp2_ready", 32'(bus.in_ready), 32'd0);
        idle(1);
        chk("li_after_ready", 32'(bus.in_ready), 32'd1);
        idle(1);

        // HLT then rebase
        expect_wr(8'h02, 16'hF000);
        send(5'h0F, 4'd0, 4'd0, 4'd0, 16'h0000);
        idle(1);
        chk("hlt_done", 32'(done), 32'd1);
        chk("hlt_ready", 32'(bus.in_ready), 32'd0);
        do_base(8'h40);
        chk("rebase_done", 32'(done), 32'd0);
        expect_wr(8'h40, 16'h0123);
        send(5'h00, 4'd1, 4'd2, 4'd3, 16'h0000);
        idle(2);
        chk("hlt_drained", 32'(sb.size()), 32'd0);

        // LI with one slot left
        do_base(8'hFE);
        expect_wr(8'hFE, 16'h0000);
        send(5'h00, 4'd0, 4'd0, 4'd0, 16'h0000);
        send(5'h10, 4'd1, 4'd0, 4'd0, 16'h1234);
        idle(2);
        chk("li_ovfl_err", 32'(err), 32'd3);
        chk("li_ovfl_done", 32'(done), 32'd1);
        chk("li_ovfl_ready", 32'(bus.in_ready), 32'd0);
        chk("li_ovfl_drained", 32'(sb.size()), 32'd0);

        // Encoding formats and range boundaries
        do_base(8'h10);
        expect_wr(8'h10, 16'h512F);
        send(5'h05, 4'd1, 4'd2, 4'd0, 16'd15);
        send(5'h07, 4'd1, 4'd2, 4'd0, 16'd16);
        send(5'h05, 4'd1, 4'd2, 4'd0, 16'hFFFF);
        expect_wr(8'h11, 16'hA3FF);
        send(5'h0A, 4'd3, 4'd0, 4'd0, 16'd255);
        expect_wr(8'h12, 16'hB480);
        send(5'h0B, 4'd4, 4'd0, 4'd0, 16'hFF80);
        expect_wr(8'h13, 16'hCB00);
        send(5'h0C, 4'd5, 4'd0, 4'd0, 16'hFF00);
        send(5'h0C, 4'd5, 4'd0, 4'd0, 16'd256);
        expect_wr(8'h14, 16'hD800);
        send(5'h0D, 4'd0, 4'd0, 4'd0, 16'hF800);
        send(5'h0D, 4'd0, 4'd0, 4'd0, 16'd2048);
        expect_wr(8'h15, 16'hE090);
        send(5'h0E, 4'd0, 4'd9, 4'd0, 16'h0000);
        send(5'h11, 4'd0, 4'd0, 4'd0, 16'h0000);
        expect_wr(8'h16, 16'h4123);
        send(5'h04, 4'd1, 4'd2, 4'd3, 16'h0000);
        idle(2);
        chk("sticky_range_err", 32'(err), 32'd1);
        chk("formats_drained", 32'(sb.size()), 32'd0);

        // Illegal op as first error
        do_base(8'h20);
        send(5'h1F, 4'd0, 4'd0, 4'd0, 16'h0000);
        idle(2);
        chk("badop_err", 32'(err), 32'd2);

        // Last slot fills memory
        do_base(8'hFF);
        expect_wr(8'hFF, 16'h0777);
        send(5'h00, 4'd7, 4'd7, 4'd7, 16'h0000);
        idle(2);
        chk("full_ready", 32'(bus.in_ready), 32'd0);
        chk("full_err", 32'(err), 32'd0);
        chk("full_done", 32'(done), 32'd0);
        chk("full_drained", 32'(sb.size()), 32'd0);

        // Reset in the middle of LI expansion
        do_base(8'h00);
        send(5'h10, 4'd7, 4'd0, 4'd0, 16'h5AA5);
        chk("mid_li_llb_we", 32'(im_we), 32'd1);
        chk("mid_li_llb", 32'({im_addr, im_wdata}), 32'h00B7A5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we",    32'(im_we),    32'd0);
        chk("mid_rst_addr",  32'(im_addr),  32'h00);
        chk("mid_rst_wdata", 32'(im_wdata), 32'h0000);
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);
        chk("final_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
